riscv_multicycle_ctrl: RTL and testbench

- Multicycle control FSM for the multicycle rework of the RV32 core.
- Single memory is shared for instruction and data, with one ALU and registered IR/ALUOut/Data/OldPC.
- Sequences fetch, decode, execute, memory and writeback, and stalls on a memory ready handshake.
- Faults to a HALT state on an illegal instruction or memory timeout.

---
 rtl/riscv_multicycle_ctrl_if.sv | 18 +
 rtl/riscv_multicycle_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_riscv_multicycle_ctrl.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_multicycle_ctrl_if.sv
// Shared instruction/data memory handshake between the multicycle
// controller (master) and the memory port (slave).
interface riscv_multicycle_ctrl_if;
  logic mem_ready;
  logic mem_read;
  logic mem_write;
  logic adr_src;

  modport master (
    output mem_read, mem_write, adr_src,
    input  mem_ready
  );

  modport slave (
    input  mem_read, mem_write, adr_src,
    output mem_ready
  );
endinterface

// File: rtl/riscv_multicycle_ctrl.sv
// Multicycle RV32 control FSM: fetch/decode/execute/memory/writeback
// over one shared memory, with illegal-instruction and bus-timeout halt.
module riscv_multicycle_ctrl #(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       zero,
  riscv_multicycle_ctrl_if.master mem,
  output logic       pc_write,
  output logic       ir_write,
  output logic       wr_en,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] imm_src,
  output logic [1:0] result_src,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal,
  output logic       bus_err
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    HALT     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;

  localparam logic [7:0] WAIT_MAX = 8'(MEM_WAIT_MAX);

  state_t     state_q, state_d;
  logic [7:0] wait_q;
  logic       ill_set, berr_set;
  logic       is_ld, is_st, is_r, is_i, is_br, is_jal;
  logic       f3_ok, wait_st, expired;
  logic [2:0] alu_fn;
  state_t     dec_next;
  logic       mem_read_c, mem_write_c, adr_src_c;
  logic       unused_f7;

  assign unused_f7 = ^{funct7[6], funct7[4:0]};

  always_comb begin
    is_ld   = opcode == OP_LOAD;
    is_st   = opcode == OP_STORE;
    is_r    = opcode == OP_R;
    is_i    = opcode == OP_I;
    is_br   = opcode == OP_BR;
    is_jal  = opcode == OP_JAL;
    f3_ok   = funct3 inside {3'b000, 3'b010, 3'b100, 3'b110, 3'b111};
    wait_st = state_q inside {FETCH, MEMREAD, MEMWRITE};
    expired = !mem.mem_ready && wait_q == WAIT_MAX;
  end

  // Only R-type ADD flips to SUB; immediate forms ignore funct7.
  always_comb begin
    alu_fn = ALU_ADD;
    unique case (funct3)
      3'b000:  alu_fn = (is_r && funct7[5]) ? ALU_SUB : ALU_ADD;
      3'b111:  alu_fn = ALU_AND;
      3'b110:  alu_fn = ALU_OR;
      3'b010:  alu_fn = ALU_SLT;
      3'b100:  alu_fn = ALU_XOR;
      default: alu_fn = ALU_ADD;
    endcase
  end

  always_comb begin
    dec_next = HALT;
    unique case (1'b1)
      is_ld, is_st: dec_next = MEMADR;
      is_r:         dec_next = f3_ok ? EXECR : HALT;
      is_i:         dec_next = f3_ok ? EXECI : HALT;
      is_br:        dec_next = (funct3 == 3'b000) ? BEQ : HALT;
      is_jal:       dec_next = JAL;
      default:      dec_next = HALT;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    ill_set     = 1'b0;
    berr_set    = 1'b0;
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    wr_en       = 1'b0;
    adr_src_c   = 1'b0;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_op      = ALU_ADD;
    imm_src     = 2'b00;
    result_src  = 2'b00;
    instr_done  = 1'b0;
    unique case (state_q)
      FETCH: begin
        mem_read_c = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (mem.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = DECODE;
        end else if (expired) begin
          berr_set = 1'b1;
          state_d  = HALT;
        end
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = is_jal ? 2'b11 : 2'b10;
        state_d   = dec_next;
        ill_set   = dec_next == HALT;
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = is_st ? 2'b01 : 2'b00;
        state_d   = is_st ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        adr_src_c  = 1'b1;
        mem_read_c = 1'b1;
        if (mem.mem_ready) begin
          state_d = MEMWB;
        end else if (expired) begin
          berr_set = 1'b1;
          state_d  = HALT;
        end
      end
      MEMWB: begin
        result_src = 2'b01;
        wr_en      = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      MEMWRITE: begin
        adr_src_c   = 1'b1;
        mem_write_c = 1'b1;
        if (mem.mem_ready) begin
          instr_done = 1'b1;
          state_d    = FETCH;
        end else if (expired) begin
          berr_set = 1'b1;
          state_d  = HALT;
        end
      end
      EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = alu_fn;
        state_d   = ALUWB;
      end
      EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = alu_fn;
        state_d   = ALUWB;
      end
      ALUWB: begin
        wr_en      = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      BEQ: begin
        alu_src_a  = 2'b10;
        alu_op     = ALU_SUB;
        pc_write   = zero;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      JAL: begin
        pc_write  = 1'b1;
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        state_d   = ALUWB;
      end
      HALT:    state_d = HALT;
      default: state_d = HALT;
    endcase
  end

  assign mem.mem_read  = mem_read_c;
  assign mem.mem_write = mem_write_c;
  assign mem.adr_src   = adr_src_c;
  assign state         = state_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= FETCH;
      wait_q  <= '0;
      illegal <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q)
        wait_q <= '0;
      else if (wait_st && !mem.mem_ready)
        wait_q <= wait_q + 8'd1;
      if (ill_set)
        illegal <= 1'b1;
      if (berr_set)
        bus_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Directed bench for riscv_multicycle_ctrl: per-cycle expected control
// words are queued as stimulus is driven and checked at the falling edge.
module tb_riscv_multicycle_ctrl;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic       adr;
    logic       mr;
    logic       mw;
    logic       irw;
    logic       wr;
    logic [1:0] a;
    logic [1:0] b;
    logic [2:0] op;
    logic [1:0] imm;
    logic [1:0] res;
    logic       done;
    logic       ill;
    logic       berr;
  } exp_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  logic       clk = 1'b0;
  logic       nrst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       zero;
  logic       pc_write, ir_write, wr_en, instr_done;
  logic       illegal, bus_err;
  logic [1:0] alu_src_a, alu_src_b, imm_src, result_src;
  logic [2:0] alu_op;
  logic [3:0] state;
  exp_t       obs;

  exp_t  sb_q[$];
  string tag_q[$];
  int    total  = 0;
  int    passed = 0;

  riscv_multicycle_ctrl_if bus ();

  riscv_multicycle_ctrl #(.MEM_WAIT_MAX(15)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .opcode     (opcode),
    .funct3     (funct3),
    .funct7     (funct7),
    .zero       (zero),
    .mem        (bus),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .wr_en      (wr_en),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .imm_src    (imm_src),
    .result_src (result_src),
    .state      (state),
    .instr_done (instr_done),
    .illegal    (illegal),
    .bus_err    (bus_err)
  );

  always #5 clk = ~clk;

  always_comb
    obs = {state, pc_write, bus.adr_src, bus.mem_read, bus.mem_write,
           ir_write, wr_en, alu_src_a, alu_src_b, alu_op, imm_src,
           result_src, instr_done, illegal, bus_err};

  function automatic exp_t mk(
    input logic [3:0] st, input logic pcw, input logic adr,
    input logic mr, input logic mw, input logic irw, input logic wr,
    input logic [1:0] a, input logic [1:0] b, input logic [2:0] op,
    input logic [1:0] imm, input logic [1:0] res, input logic done,
    input logic ill = 1'b0, input logic berr = 1'b0);
    return {st, pcw, adr, mr, mw, irw, wr, a, b, op, imm, res,
            done, ill, berr};
  endfunction

  function automatic exp_t x_fetch(input logic rdy);
    return mk(4'd0, rdy, 0, 1, 0, rdy, 0, 2'b00, 2'b10, 3'b000,
              2'b00, 2'b10, 0);
  endfunction
  function automatic exp_t x_decode(input logic j);
    return mk(4'd1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 3'b000,
              j ? 2'b11 : 2'b10, 2'b00, 0);
  endfunction
  function automatic exp_t x_memadr(input logic st);
    return mk(4'd2, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 3'b000,
              st ? 2'b01 : 2'b00, 2'b00, 0);
  endfunction
  function automatic exp_t x_memread();
    return mk(4'd3, 0, 1, 1, 0, 0, 0, 2'b00, 2'b00, 3'b000,
              2'b00, 2'b00, 0);
  endfunction
  function automatic exp_t x_memwb();
    return mk(4'd4, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000,
              2'b00, 2'b01, 1);
  endfunction
  function automatic exp_t x_memwrite(input logic rdy);
    return mk(4'd5, 0, 1, 0, 1, 0, 0, 2'b00, 2'b00, 3'b000,
              2'b00, 2'b00, rdy);
  endfunction
  function automatic exp_t x_execr(input logic [2:0] op);
    return mk(4'd6, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, op,
              2'b00, 2'b00, 0);
  endfunction
  function automatic exp_t x_execi(input logic [2:0] op);
    return mk(4'd7, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, op,
              2'b00, 2'b00, 0);
  endfunction
  function automatic exp_t x_aluwb();
    return mk(4'd8, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000,
              2'b00, 2'b00, 1);
  endfunction
  function automatic exp_t x_beq(input logic z);
    return mk(4'd9, z, 0, 0, 0, 0, 0, 2'b10, 2'b00, 3'b001,
              2'b00, 2'b00, 1);
  endfunction
  function automatic exp_t x_jal();
    return mk(4'd10, 1, 0, 0, 0, 0, 0, 2'b01, 2'b10, 3'b000,
              2'b00, 2'b00, 0);
  endfunction
  function automatic exp_t x_halt(input logic ill, input logic berr);
    return mk(4'd15, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000,
              2'b00, 2'b00, 0, ill, berr);
  endfunction

  task automatic compare();
    exp_t  e;
    string t;
    e = sb_q.pop_front();
    t = tag_q.pop_front();
    total++;
    assert (obs === e) passed++;
    else $error("FAIL %s: observed %h expected %h", t, obs, e);
  endtask

  task automatic set_ir(input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7);
    opcode = op;
    funct3 = f3;
    funct7 = f7;
  endtask

  // Entered and left at posedge+1; checks at the following negedge.
  task automatic step(input string tag, input logic z, input logic rdy,
                      input exp_t e);
    zero          = z;
    bus.mem_ready = rdy;
    sb_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    nrst          = 1'b0;
    zero          = 1'b0;
    bus.mem_ready = 1'b0;
    sb_q.push_back(x_fetch(1'b0));
    tag_q.push_back(tag);
    #1;
    compare();
    @(posedge clk);
    #1;
    nrst = 1'b1;
  endtask

  initial begin
    nrst          = 1'b1;
    zero          = 1'b0;
    bus.mem_ready = 1'b0;
    set_ir(OP_R, 3'b000, 7'b0000000);
    #2;
    do_reset("reset");

    step("add_fetch", 0, 1, x_fetch(1));
    step("add_decode", 0, 1, x_decode(0));
    step("add_exec", 0, 1, x_execr(3'b000));
    step("add_wb", 0, 1, x_aluwb());
    set_ir(OP_R, 3'b000, 7'b0100000);
    step("sub_fetch", 0, 1, x_fetch(1));
    step("sub_decode", 0, 1, x_decode(0));
    step("sub_exec", 0, 1, x_execr(3'b001));
    step("sub_wb", 0, 1, x_aluwb());

    set_ir(OP_I, 3'b000, 7'b0100000);
    step("addi_fetch", 0, 1, x_fetch(1));
    step("addi_decode", 0, 1, x_decode(0));
    step("addi_exec", 0, 1, x_execi(3'b000));
    step("addi_wb", 0, 1, x_aluwb());
    set_ir(OP_R, 3'b111, 7'b0000000);
    step("and_fetch", 0, 1, x_fetch(1));
    step("and_decode", 0, 1, x_decode(0));
    step("and_exec", 0, 1, x_execr(3'b010));
    step("and_wb", 0, 1, x_aluwb());

    set_ir(OP_LOAD, 3'b010, 7'b0000000);
    step("lw_fetch", 0, 1, x_fetch(1));
    step("lw_decode", 0, 1, x_decode(0));
    step("lw_memadr", 0, 1, x_memadr(0));
    for (int i = 0; i < 3; i++)
      step("lw_memread_wait", 0, 0, x_memread());
    step("lw_memread_rdy", 0, 1, x_memread());
    step("lw_memwb", 0, 0, x_memwb());

    set_ir(OP_STORE, 3'b010, 7'b0000000);
    step("sw_fetch", 0, 1, x_fetch(1));
    step("sw_decode", 0, 1, x_decode(0));
    step("sw_memadr", 0, 1, x_memadr(1));
    step("sw_memwrite_wait", 0, 0, x_memwrite(0));
    step("sw_memwrite_wait", 0, 0, x_memwrite(0));
    step("sw_memwrite_rdy", 0, 1, x_memwrite(1));

    set_ir(OP_BR, 3'b000, 7'b0000000);
    step("beq1_fetch", 0, 1, x_fetch(1));
    step("beq1_decode", 0, 1, x_decode(0));
    step("beq1_taken", 1, 1, x_beq(1));
    step("beq0_fetch", 0, 1, x_fetch(1));
    step("beq0_decode", 0, 1, x_decode(0));
    step("beq0_not_taken", 0, 1, x_beq(0));

    set_ir(OP_JAL, 3'b000, 7'b0000000);
    step("jal_fetch", 0, 1, x_fetch(1));
    step("jal_decode", 0, 1, x_decode(1));
    step("jal_exec", 0, 1, x_jal());
    step("jal_wb", 0, 1, x_aluwb());

    set_ir(OP_STORE, 3'b010, 7'b0000000);
    step("sw2_fetch", 0, 1, x_fetch(1));
    step("sw2_decode", 0, 1, x_decode(0));
    step("sw2_memadr", 0, 1, x_memadr(1));
    step("sw2_memwrite", 0, 0, x_memwrite(0));
    do_reset("reset_mid_write");

    set_ir(7'b1111111, 3'b000, 7'b0000000);
    step("bad_fetch", 0, 1, x_fetch(1));
    step("bad_decode", 0, 1, x_decode(0));
    step("bad_halt", 0, 1, x_halt(1, 0));
    step("bad_halt_rdy0", 0, 0, x_halt(1, 0));
    step("bad_halt_rdy1", 1, 1, x_halt(1, 0));
    do_reset("reset_clears_illegal");

    set_ir(OP_R, 3'b001, 7'b0000000);
    step("badf3_fetch", 0, 1, x_fetch(1));
    step("badf3_decode", 0, 1, x_decode(0));
    step("badf3_halt", 0, 1, x_halt(1, 0));
    set_ir(OP_BR, 3'b001, 7'b0000000);
    do_reset("reset_after_badf3");
    step("bne_fetch", 0, 1, x_fetch(1));
    step("bne_decode", 0, 1, x_decode(0));
    step("bne_halt", 0, 1, x_halt(1, 0));

    set_ir(OP_R, 3'b000, 7'b0000000);
    do_reset("reset_before_timeout");
    for (int i = 0; i < 16; i++)
      step("fetch_wait", 0, 0, x_fetch(0));
    step("fetch_timeout_halt", 0, 0, x_halt(0, 1));
    step("timeout_halt_rdy", 0, 1, x_halt(0, 1));

    do_reset("reset_clears_bus_err");
    for (int i = 0; i < 15; i++)
      step("fetch_wait2", 0, 0, x_fetch(0));
    step("fetch_last_rdy", 0, 1, x_fetch(1));
    step("fetch_late_decode", 0, 1, x_decode(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
